// File: rtl/psum_adder_n_pkg.sv
// Shared widths, packet field offsets and the input packet layout for psum_adder_n.

`define PSUM_IN_PKT_T(AW, LW, DW) struct packed { logic [(AW)-1:0] dest; logic [(AW)-1:0] src; logic [(LW)-1:0] lane; logic [(DW)-1:0] data; }

package psum_pkg;

    // Ceiling log2; clog2_f(1) is 0.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w_f(input int n);
        return (clog2_f(n) < 1) ? 1 : clog2_f(n);
    endfunction

    // Result width: saturating mode keeps the input width, widening mode grows it.
    function automatic int owidth_f(input int dw, input int sat, input int n, input int acc);
        return (sat != 0) ? dw : dw + clog2_f(n) + clog2_f(acc);
    endfunction

    // Field offsets inside a {dest, src, lane, data} packet.
    function automatic int data_lsb_f();
        return 0;
    endfunction

    function automatic int lane_lsb_f(input int dw);
        return dw;
    endfunction

    function automatic int src_lsb_f(input int dw, input int lw);
        return dw + lw;
    endfunction

    function automatic int dest_lsb_f(input int dw, input int lw, input int aw);
        return dw + lw + aw;
    endfunction

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DWIDTH = 8;
    localparam int DEF_NUM_IN = 3;

    typedef `PSUM_IN_PKT_T(DEF_ADDR_W, idx_w_f(DEF_NUM_IN), DEF_DWIDTH) psum_in_pkt_def_t;

endpackage

// File: rtl/psum_adder_n_if.sv
// Valid/ready packet stream used for both the input and the output side.

interface psum_adder_n_if
    import psum_pkg::*;
#(
    parameter int W = 2 * DEF_ADDR_W + idx_w_f(DEF_NUM_IN) + DEF_DWIDTH
);
    logic         valid;
    logic         ready;
    logic [W-1:0] pkt;

    modport master (output valid, output pkt, input ready);
    modport slave  (input valid, input pkt, output ready);
endinterface

// File: rtl/psum_adder_n_lane_fifo.sv
// Per-lane FIFO with wrap-bit pointers; pushes into a full FIFO and pops from an empty one are ignored.

module psum_lane_fifo
    import psum_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = clog2_f(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the pointers; reset empties the FIFO and discards its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; its contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/psum_adder_n.sv
// Lane-tagged partial-sum collector: per-lane FIFOs, adder tree, optional accumulation and result packetizer.

module psum_adder_n
    import psum_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int NUM_IN   = 3,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 4,
    parameter int SAT_MODE = 1,
    parameter int ACC_LEN  = 1,
    parameter int MY_ADDR  = 0,
    parameter int OUT_DEST = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    psum_adder_n_if.slave  in_if,
    psum_adder_n_if.master out_if,
    output logic           sat_flag,
    output logic           lane_err
);
    localparam int LANE_W     = idx_w_f(NUM_IN);
    localparam int OWIDTH     = owidth_f(DWIDTH, SAT_MODE, NUM_IN, ACC_LEN);
    localparam int OPWIDTH    = 2 * ADDR_W + LANE_W + OWIDTH;
    localparam int IW         = DWIDTH + clog2_f(NUM_IN) + clog2_f(ACC_LEN) + 1;
    localparam int CNT_W      = idx_w_f(ACC_LEN);
    localparam int O_DATA_LSB = data_lsb_f();
    localparam int O_LANE_LSB = lane_lsb_f(OWIDTH);
    localparam int O_SRC_LSB  = src_lsb_f(OWIDTH, LANE_W);
    localparam int O_DEST_LSB = dest_lsb_f(OWIDTH, LANE_W, ADDR_W);

    localparam logic signed [IW-1:0] SAT_MAX = {{(IW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = {{(IW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    typedef `PSUM_IN_PKT_T(ADDR_W, LANE_W, DWIDTH) in_pkt_t;

    in_pkt_t                  in_fields;
    logic [NUM_IN-1:0]        lane_hit;
    logic [NUM_IN-1:0]        push_vec;
    logic [NUM_IN-1:0]        full_vec;
    logic [NUM_IN-1:0]        empty_vec;
    logic signed [DWIDTH-1:0] lane_data [NUM_IN];
    logic                     lane_ok;
    logic                     sel_full;
    logic                     accept;
    logic                     last_round;
    logic                     out_can;
    logic                     fire;
    logic                     clamp;
    logic signed [IW-1:0]     acc;
    logic signed [IW-1:0]     lane_sum;
    logic signed [IW-1:0]     acc_raw;
    logic signed [IW-1:0]     acc_next;
    logic [CNT_W-1:0]         round_cnt;
    logic [OPWIDTH-1:0]       out_word;
    logic                     unused_addr;

    assign in_fields   = in_if.pkt;
    assign unused_addr = ^{in_fields.dest, in_fields.src};

    // One-hot decode of the lane field; an out-of-range lane decodes to no lane at all.
    always_comb begin
        lane_hit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lane_hit[i] = (int'(in_fields.lane) == i);
        end
    end

    assign lane_ok      = |lane_hit;
    assign sel_full     = |(lane_hit & full_vec);
    assign in_if.ready  = rst_n & ~sel_full;
    assign accept       = in_if.valid & in_if.ready;
    assign push_vec     = lane_hit & {NUM_IN{accept}};

    assign last_round   = (round_cnt == CNT_W'(ACC_LEN - 1));
    assign out_can      = ~out_if.valid | out_if.ready | ~last_round;
    assign fire         = (&(~empty_vec)) & out_can;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
        psum_lane_fifo #(
            .DWIDTH (DWIDTH),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[g]),
            .push_data (in_fields.data),
            .pop       (fire),
            .pop_data  (lane_data[g]),
            .full      (full_vec[g]),
            .empty     (empty_vec[g])
        );
    end

    // Sign-extended adder tree over the FIFO heads, added to the running accumulator and clamped if saturating.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lane_sum = lane_sum + IW'($signed(lane_data[i]));
        end
        acc_raw  = acc + lane_sum;
        acc_next = acc_raw;
        clamp    = 1'b0;
        if (SAT_MODE != 0) begin
            if (acc_raw > SAT_MAX) begin
                acc_next = SAT_MAX;
                clamp    = 1'b1;
            end else if (acc_raw < SAT_MIN) begin
                acc_next = SAT_MIN;
                clamp    = 1'b1;
            end
        end
    end

    // Assemble the outgoing packet; the lane field of a result is always zero.
    always_comb begin
        out_word = '0;
        out_word[O_DATA_LSB +: OWIDTH] = acc_next[OWIDTH-1:0];
        out_word[O_LANE_LSB +: LANE_W] = '0;
        out_word[O_SRC_LSB  +: ADDR_W] = ADDR_W'(MY_ADDR);
        out_word[O_DEST_LSB +: ADDR_W] = ADDR_W'(OUT_DEST);
    end

    // Accumulator and round counter; both restart after the last round of a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            round_cnt <= '0;
        end else if (fire) begin
            if (last_round) begin
                acc       <= '0;
                round_cnt <= '0;
            end else begin
                acc       <= acc_next;
                round_cnt <= round_cnt + CNT_W'(1);
            end
        end
    end

    // Output holding register: loads on a last-round fire, otherwise clears once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_if.valid <= 1'b0;
            out_if.pkt   <= '0;
        end else if (fire && last_round) begin
            out_if.valid <= 1'b1;
            out_if.pkt   <= out_word;
        end else if (out_if.ready) begin
            out_if.valid <= 1'b0;
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            lane_err <= 1'b0;
        end else begin
            if (fire && clamp)       sat_flag <= 1'b1;
            if (accept && !lane_ok)  lane_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_adder_n.sv
// Bench for psum_adder_n: three instances (saturating, widening, 4-round accumulating) checked against a queue model.

module tb_psum_adder_n;

    logic clk;
    logic rst_n;

    logic [2:0]  in_valid_v;
    logic [2:0]  in_ready_v;
    logic [17:0] in_pkt_d [3];
    logic [2:0]  out_ready_v;
    logic [2:0]  out_valid_v;
    logic [19:0] out_pkt_o [3];
    logic [2:0]  sat_v;
    logic [2:0]  err_v;

    psum_adder_n_if #(.W(18)) in0 ();
    psum_adder_n_if #(.W(18)) out0 ();
    psum_adder_n_if #(.W(18)) in1 ();
    psum_adder_n_if #(.W(20)) out1 ();
    psum_adder_n_if #(.W(18)) in2 ();
    psum_adder_n_if #(.W(18)) out2 ();

    assign in0.valid = in_valid_v[0];
    assign in1.valid = in_valid_v[1];
    assign in2.valid = in_valid_v[2];
    assign in0.pkt   = in_pkt_d[0];
    assign in1.pkt   = in_pkt_d[1];
    assign in2.pkt   = in_pkt_d[2];
    assign in_ready_v = {in2.ready, in1.ready, in0.ready};
    assign out0.ready = out_ready_v[0];
    assign out1.ready = out_ready_v[1];
    assign out2.ready = out_ready_v[2];
    assign out_valid_v = {out2.valid, out1.valid, out0.valid};
    assign out_pkt_o[0] = {2'b00, out0.pkt};
    assign out_pkt_o[1] = out1.pkt;
    assign out_pkt_o[2] = {2'b00, out2.pkt};

    psum_adder_n #(.SAT_MODE(1), .ACC_LEN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_if(in0), .out_if(out0), .sat_flag(sat_v[0]), .lane_err(err_v[0]));
    psum_adder_n #(.SAT_MODE(0), .ACC_LEN(1)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_if(in1), .out_if(out1), .sat_flag(sat_v[1]), .lane_err(err_v[1]));
    psum_adder_n #(.SAT_MODE(1), .ACC_LEN(4)) u_acc (
        .clk(clk), .rst_n(rst_n), .in_if(in2), .out_if(out2), .sat_flag(sat_v[2]), .lane_err(err_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit rand_ready = 0;

    int sat_mode [3] = '{1, 0, 1};
    int acc_len  [3] = '{1, 1, 4};
    int ow       [3] = '{8, 10, 8};

    int          mq [9][$];
    int          exp_q [3][$];
    logic [19:0] rx_q [3][$];
    int          macc [3];
    int          mround [3];
    bit          mflag [3];

    // Collect every completed output handshake, sampled well after the falling edge.
    always @(negedge clk) begin
        #3;
        for (int d = 0; d < 3; d++) begin
            if (out_valid_v[d] && out_ready_v[d]) rx_q[d].push_back(out_pkt_o[d]);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic modelReset();
        for (int i = 0; i < 9; i++) mq[i].delete();
        for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            rx_q[d].delete();
            macc[d]   = 0;
            mround[d] = 0;
            mflag[d]  = 0;
        end
    endtask

    // Reference: a round happens whenever every lane holds a value; results come out in round order.
    task automatic modelPush(input int d, input int lane, input int data);
        int s;
        if (lane > 2) return;
        mq[d*3+lane].push_back(data);
        while (mq[d*3].size() > 0 && mq[d*3+1].size() > 0 && mq[d*3+2].size() > 0) begin
            s = macc[d] + mq[d*3].pop_front() + mq[d*3+1].pop_front() + mq[d*3+2].pop_front();
            if (sat_mode[d] != 0 && s > 127)  begin s = 127;  mflag[d] = 1; end
            if (sat_mode[d] != 0 && s < -128) begin s = -128; mflag[d] = 1; end
            macc[d] = s;
            mround[d]++;
            if (mround[d] == acc_len[d]) begin
                exp_q[d].push_back(s);
                macc[d]   = 0;
                mround[d] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_ready) out_ready_v = 3'($urandom_range(0, 7));
    endtask

    task automatic applyStimulus(input int d, input int lane, input int data);
        int waited;
        waited = 0;
        tick();
        in_valid_v[d] = 1'b1;
        in_pkt_d[d]   = {4'($urandom), 4'($urandom), 2'(lane), 8'(data)};
        #1;
        while (!in_ready_v[d] && waited < 200) begin
            tick();
            #1;
            waited++;
        end
        if (!in_ready_v[d]) begin
            checkOutput("push_timeout", 32'(in_ready_v[d]), 1);
            in_valid_v[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid_v[d] = 1'b0;
        modelPush(d, lane, data);
    endtask

    function automatic void decode(input int d, input logic [19:0] p, output int sum,
                                   output int lane, output int src, output int dest);
        logic [19:0] t;
        int w;
        w    = ow[d];
        t    = p & ((20'd1 << w) - 20'd1);
        sum  = int'(t);
        if (t[w-1]) sum = sum - (1 << w);
        lane = int'((p >> w) & 20'd3);
        src  = int'((p >> (w + 2)) & 20'hF);
        dest = int'((p >> (w + 6)) & 20'hF);
    endfunction

    task automatic checkDrain(input int d);
        int waited, sum, lane, src, dest, e;
        logic [19:0] p;
        waited = 0;
        while (rx_q[d].size() < exp_q[d].size() && waited < 300) begin
            tick();
            waited++;
        end
        repeat (4) tick();
        checkOutput($sformatf("count_d%0d", d), 32'(rx_q[d].size()), 32'(exp_q[d].size()));
        while (rx_q[d].size() > 0 && exp_q[d].size() > 0) begin
            p = rx_q[d].pop_front();
            e = exp_q[d].pop_front();
            decode(d, p, sum, lane, src, dest);
            checkOutput($sformatf("sum_d%0d", d), sum, e);
            if (lane != 0 || src != 0 || dest != 1)
                checkOutput($sformatf("hdr_d%0d", d), {lane[7:0], src[7:0], dest[7:0]}, 32'h000001);
        end
        rx_q[d].delete();
        exp_q[d].delete();
    endtask

    initial begin
        int sum, lane, src, dest, d, v;
        in_valid_v  = '0;
        out_ready_v = 3'b111;
        for (int i = 0; i < 3; i++) in_pkt_d[i] = '0;
        modelReset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready_v), 0);
        checkOutput("rst_out_valid", 32'(out_valid_v), 0);
        checkOutput("rst_out_pkt", 32'(out_pkt_o[0]), 0);
        checkOutput("rst_flags", 32'({sat_v, err_v}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready_v), 32'h7);

        $display("[TB] basic round with latency");
        applyStimulus(0, 0, 10);
        applyStimulus(0, 1, 20);
        applyStimulus(0, 2, -5);
        checkOutput("lat_t1_valid", 32'(out_valid_v[0]), 0);
        @(posedge clk);
        #1;
        checkOutput("lat_t2_valid", 32'(out_valid_v[0]), 1);
        decode(0, out_pkt_o[0], sum, lane, src, dest);
        checkOutput("basic_sum", sum, 25);
        checkOutput("basic_dest", dest, 1);
        checkOutput("basic_src", src, 0);
        checkDrain(0);

        $display("[TB] saturation");
        applyStimulus(0, 0, 100);
        applyStimulus(0, 1, 100);
        applyStimulus(0, 2, 50);
        checkDrain(0);
        checkOutput("sat_flag_set", 32'(sat_v[0]), 1);
        applyStimulus(0, 0, -128);
        applyStimulus(0, 1, -1);
        applyStimulus(0, 2, 0);
        checkDrain(0);

        $display("[TB] widening");
        applyStimulus(1, 0, 127);
        applyStimulus(1, 1, 127);
        applyStimulus(1, 2, 127);
        checkDrain(1);
        checkOutput("wide_sat_flag", 32'(sat_v[1]), 0);

        $display("[TB] accumulation");
        for (int r = 0; r < 3; r++) begin
            applyStimulus(2, 0, 1);
            applyStimulus(2, 1, 2);
            applyStimulus(2, 2, 3);
        end
        repeat (5) tick();
        checkOutput("acc_no_early_valid", 32'(out_valid_v[2]), 0);
        checkOutput("acc_no_early_pkt", 32'(rx_q[2].size()), 0);
        applyStimulus(2, 0, 1);
        applyStimulus(2, 1, 2);
        applyStimulus(2, 2, 3);
        checkDrain(2);

        $display("[TB] back-pressure and full FIFO");
        out_ready_v[0] = 1'b0;
        applyStimulus(0, 0, 7);
        applyStimulus(0, 1, 8);
        applyStimulus(0, 2, 9);
        repeat (3) tick();
        checkOutput("bp_pending_valid", 32'(out_valid_v[0]), 1);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, i);
        tick();
        in_valid_v[0] = 1'b1;
        in_pkt_d[0]   = {4'd1, 4'd2, 2'd0, 8'd5};
        #1;
        checkOutput("bp_full_in_ready", 32'(in_ready_v[0]), 0);
        in_valid_v[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 10 * i);
            applyStimulus(0, 2, -3 * i);
        end
        repeat (3) tick();
        decode(0, out_pkt_o[0], sum, lane, src, dest);
        checkOutput("bp_stable_sum", sum, 24);
        checkOutput("bp_stable_valid", 32'(out_valid_v[0]), 1);
        checkOutput("bp_no_drain", 32'(rx_q[0].size()), 0);
        out_ready_v[0] = 1'b1;
        applyStimulus(0, 0, 5);
        applyStimulus(0, 1, 50);
        applyStimulus(0, 2, -15);
        checkDrain(0);

        $display("[TB] bad lane");
        applyStimulus(0, 3, 55);
        tick();
        checkOutput("lane_err_set", 32'(err_v[0]), 1);
        checkOutput("lane_err_other", 32'(err_v[1]), 0);
        checkDrain(0);

        $display("[TB] randomized traffic");
        rand_ready = 1;
        for (int n = 0; n < 150; n++) begin
            d    = $urandom_range(0, 2);
            lane = $urandom_range(0, 2);
            if (mq[d*3+lane].size() >= 4) begin
                for (int l = 0; l < 3; l++) if (mq[d*3+l].size() == 0) lane = l;
            end
            v = int'($urandom_range(0, 255)) - 128;
            applyStimulus(d, lane, v);
        end
        rand_ready  = 0;
        out_ready_v = 3'b111;
        for (int k = 0; k < 3; k++) begin
            checkDrain(k);
            checkOutput($sformatf("rand_sat_flag_d%0d", k), 32'(sat_v[k]), 32'(mflag[k]));
        end

        $display("[TB] reset mid-round");
        applyStimulus(0, 0, 3);
        applyStimulus(0, 1, 4);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready_v[0]), 0);
        checkOutput("mid_rst_out_valid", 32'(out_valid_v[0]), 0);
        tick();
        tick();
        rst_n = 1'b1;
        modelReset();
        #1;
        checkOutput("mid_rst_flags", 32'({sat_v, err_v}), 0);
        checkOutput("mid_rst_out_pkt", 32'(out_pkt_o[0]), 0);
        applyStimulus(0, 2, 6);
        repeat (5) tick();
        checkOutput("mid_rst_fifos_empty", 32'(out_valid_v[0]), 0);
        checkOutput("mid_rst_no_output", 32'(rx_q[0].size()), 0);
        applyStimulus(0, 0, -40);
        applyStimulus(0, 1, 11);
        checkDrain(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/psum_adder_n.md
Name: psum_adder_n

Overview:
- Clocked, parametrised successor to the fixed 3-input partial-sum adder chain: depacketizer, per-lane queues, adder and packetizer in one block.
- Accepts single-value partial-sum packets tagged with a lane index and buffers each lane in its own FIFO.
- When every lane holds a value, pops one from each lane and adds them, in saturating or widening mode.
- Optionally accumulates over ACC_LEN rounds, then emits one result packet toward the next stage.

Parameters:
- DWIDTH, 8: signed two's-complement width of each partial sum.
- NUM_IN, 3: number of lanes summed per round (2..16).
- DEPTH, 4: entries per lane FIFO, power of 2, ≥2.
- ADDR_W, 4: width of the node address fields.
- SAT_MODE, 1: 1 = saturate the result to DWIDTH bits; 0 = widen the result without loss.
- ACC_LEN, 1: rounds accumulated per output packet (1..256).
- MY_ADDR, 0: source address written into output packets.
- OUT_DEST, 1: destination address written into output packets.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input packet valid
- in_ready  out  1  input packet accepted this cycle when in_valid & in_ready
- in_pkt  in  PWIDTH  {dest, src, lane, data}; PWIDTH = 2*ADDR_W+LANE_W+DWIDTH
- out_valid  out  1  output packet valid
- out_ready  in  1  downstream accepts
- out_pkt  out  OPWIDTH  {OUT_DEST, MY_ADDR, lane=0, sum}; OPWIDTH = 2*ADDR_W+LANE_W+OWIDTH
- sat_flag  out  1  sticky: a saturation clamp has occurred
- lane_err  out  1  sticky: a packet arrived with lane ≥ NUM_IN

Behaviour:
- Derived widths:
  - LANE_W = max(1, clog2(NUM_IN)).
  - OWIDTH = DWIDTH if SAT_MODE=1, else DWIDTH + clog2(NUM_IN) + clog2(ACC_LEN).
- Reset: asynchronous on rst_n low.
  - All FIFOs empty; accumulator = 0; round counter = 0.
  - out_valid = 0, out_pkt = 0, sat_flag = 0, lane_err = 0.
  - in_ready = 0 while reset is asserted.
  - Reset mid-operation discards all buffered data and any pending output.
- Input:
  - in_ready = !full[in_pkt.lane] when lane < NUM_IN; this is combinational on the lane field.
  - lane ≥ NUM_IN: in_ready = 1, the packet is dropped, lane_err is set.
  - The dest and src fields are ignored.
  - A packet accepted in cycle T is visible in its FIFO at T+1.
- Fire condition: all NUM_IN FIFOs non-empty AND the output stage can take a value. Output stage can take a value = !out_valid | out_ready, or the round is not the last of the accumulation.
- On fire:
  - Pop one entry from every lane in the same cycle.
  - Compute acc_next = acc + sign-extended sum of the lanes, at full internal width.
  - Increment the round counter.
- Saturating mode (SAT_MODE=1):
  - Clamp to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1] after each round's add.
  - A clamp sets sat_flag.
- Widening mode (SAT_MODE=0): no overflow is possible by construction.
- Last round (counter == ACC_LEN-1):
  - Load out_pkt with the result and set out_valid at T+1.
  - Reset accumulator and counter to 0 in the same edge.
- Output:
  - out_valid stays high, with out_pkt stable, until out_ready is seen.
  - Full throughput: out_valid & out_ready together with a new fire reloads out_pkt in the same cycle.
- Latency: last lane value accepted at T → fire at T+1 → out_valid at T+2.
- Simultaneous push and pop on the same lane is permitted:
  - A full FIFO still reports full (in_ready is not bypassed).
  - An empty FIFO cannot fire the same cycle as its push.
- FIFO pointers are DEPTH-wrapping with an extra wrap bit for full/empty detection.
- Sticky flags clear only on reset.

Decomposition:
- Package psum_pkg holds:
  - clog2-style width helper functions.
  - Packet field offset functions.
  - typedef of the input packet struct parameterised by widths via macros.
- One sub-module: psum_lane_fifo (DWIDTH, DEPTH), instantiated NUM_IN times via generate.
- Adder tree and accumulator live in the top level.

Test Plan:
- Basic round (NUM_IN=3, SAT=1, ACC_LEN=1): lanes 0,1,2 get 10, 20, -5 → one out_pkt with sum 25 at T+2, dest=1, src=0.
- Saturation: lanes get 100, 100, 50 → sum 127, sat_flag = 1; then -128, -1, 0 → sum -128.
- Widening (SAT=0): lanes get 127, 127, 127 → OWIDTH 10, sum 381, sat_flag stays 0.
- Accumulation (ACC_LEN=4): four rounds of 1, 2, 3 → one packet, sum 24, emitted only after round 4.
- Back-pressure and full:
  - Hold out_ready=0 and push 5 values to lane 0 with DEPTH=4 → 5th packet sees in_ready=0.
  - Pending out_pkt stays stable.
  - Release out_ready → the stalled round proceeds, no data lost.
- Error and reset: lane=3 packet → dropped, lane_err=1; rst_n pulsed mid-round with 2 lanes filled → FIFOs empty, out_valid=0, flags 0.
